// File: rtl/nios_system_nios2_gen2_0_oci_pkg.sv
// Shared OCI trace definitions: DCT code values and packet geometry.
package nios_system_nios2_gen2_0_oci_pkg;

    localparam int DCT_SLOTS = 15;
    localparam int CODE_W    = 2;
    localparam int CNT_W     = 4;
    localparam int BUF_W     = DCT_SLOTS * CODE_W;
    localparam int DROP_W    = 8;

    localparam logic [CODE_W-1:0] DCT_TAKEN     = 2'b10;
    localparam logic [CODE_W-1:0] DCT_NOT_TAKEN = 2'b01;

    function automatic logic [CODE_W-1:0] dct_code(input logic taken);
        return taken ? DCT_TAKEN : DCT_NOT_TAKEN;
    endfunction

endpackage

// File: rtl/nios_system_nios2_gen2_0_oci_pkt_reg.sv
// Single-entry valid/ready packet holding register with drop accounting.
module nios_system_nios2_gen2_0_oci_pkt_reg
    import nios_system_nios2_gen2_0_oci_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_emit,
    input  logic [BUF_W-1:0]  i_buffer,
    input  logic [CNT_W-1:0]  i_count,
    input  logic              i_ready,
    input  logic              i_ovf_clr,
    output logic              o_valid,
    output logic [BUF_W-1:0]  o_buffer,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_overflow,
    output logic [DROP_W-1:0] o_drop_cnt
);

    logic              r_valid;
    logic [BUF_W-1:0]  r_buffer;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    logic w_free;
    logic w_load;
    logic w_drop;

    assign w_free = !r_valid || i_ready;
    assign w_load = i_emit && w_free;
    assign w_drop = i_emit && !w_free;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_buffer <= '0;
            r_count  <= '0;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_buffer <= i_buffer;
            r_count  <= i_count;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (i_ovf_clr)
                r_drop_cnt <= DROP_W'(1);
            else if (r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign o_valid    = r_valid;
    assign o_buffer   = r_buffer;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: rtl/nios_system_nios2_gen2_0_oci_dct_packer.sv
// DCT trace packer: collects branch codes and emits packets on full/flush/trace-off.
module nios_system_nios2_gen2_0_oci_dct_packer
    import nios_system_nios2_gen2_0_oci_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              trc_on,
    input  logic              dct_valid,
    input  logic              dct_taken,
    input  logic              flush_req,
    input  logic              ovf_clr,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic [BUF_W-1:0]  pkt_buffer,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [BUF_W-1:0] r_buffer;
    logic [CNT_W-1:0] r_count;
    logic             r_trc_d;

    logic             w_accept;
    logic [BUF_W-1:0] w_buf_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_full;
    logic             w_flush;
    logic             w_trc_fall;
    logic             w_emit;

    assign w_accept   = trc_on && dct_valid;
    assign w_buf_next = w_accept
                      ? {r_buffer[BUF_W-CODE_W-1:0], dct_code(dct_taken)}
                      : r_buffer;
    assign w_cnt_next = r_count + CNT_W'(w_accept);

    // Count never wraps, so a nonzero post-accept count covers both flush cases.
    assign w_full     = w_accept && (w_cnt_next == CNT_W'(DCT_SLOTS));
    assign w_flush    = trc_on && flush_req && (w_cnt_next != '0);
    assign w_trc_fall = r_trc_d && !trc_on && (r_count != '0);
    assign w_emit     = w_full || w_flush || w_trc_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buffer <= '0;
            r_count  <= '0;
            r_trc_d  <= 1'b0;
        end else begin
            r_trc_d <= trc_on;
            if (w_emit) begin
                r_buffer <= '0;
                r_count  <= '0;
            end else begin
                r_buffer <= w_buf_next;
                r_count  <= w_cnt_next;
            end
        end
    end

    assign dct_buffer = r_buffer;
    assign dct_count  = r_count;

    nios_system_nios2_gen2_0_oci_pkt_reg u_pkt_reg (
        .clk        (clk),
        .reset      (reset),
        .i_emit     (w_emit),
        .i_buffer   (w_buf_next),
        .i_count    (w_cnt_next),
        .i_ready    (pkt_ready),
        .i_ovf_clr  (ovf_clr),
        .o_valid    (pkt_valid),
        .o_buffer   (pkt_buffer),
        .o_count    (pkt_count),
        .o_overflow (overflow),
        .o_drop_cnt (drop_cnt)
    );

endmodule

// File: tb/tb_nios_system_nios2_gen2_0_oci_dct_packer.sv
// Bench: queue-based packet model, per-cycle compare, directed literal checks.
module tb_nios_system_nios2_gen2_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trc_on = 1'b0;
    logic        dct_valid = 1'b0;
    logic        dct_taken = 1'b0;
    logic        flush_req = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        pkt_ready = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        pkt_valid;
    logic [29:0] pkt_buffer;
    logic [3:0]  pkt_count;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nios_system_nios2_gen2_0_oci_dct_packer dut (
        .clk        (clk),
        .reset      (reset),
        .trc_on     (trc_on),
        .dct_valid  (dct_valid),
        .dct_taken  (dct_taken),
        .flush_req  (flush_req),
        .ovf_clr    (ovf_clr),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_buffer (pkt_buffer),
        .pkt_count  (pkt_count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Model: live codes as a queue (oldest first), packet as plain values.
    logic [1:0] mq[$];
    bit         m_started = 0;
    bit         m_prev_trc = 0;
    bit         m_valid = 0;
    int         m_pbuf = 0;
    int         m_pcnt = 0;
    bit         m_ovf = 0;
    int         m_drop = 0;

    function automatic int pack_q(input logic [1:0] q[$]);
        int v = 0;
        foreach (q[i]) v = ((v * 4) + int'(q[i])) & 32'h3FFF_FFFF;
        return v;
    endfunction

    always @(posedge clk) begin
        bit emit;
        bit dropped;
        if (reset) begin
            mq.delete();
            m_started = 1;
            m_prev_trc = 0;
            m_valid = 0;
            m_pbuf = 0;
            m_pcnt = 0;
            m_ovf = 0;
            m_drop = 0;
        end else begin
            emit = 0;
            dropped = 0;
            if (m_prev_trc && !trc_on && mq.size() > 0) emit = 1;
            if (trc_on && dct_valid) begin
                mq.push_back(dct_taken ? 2'b10 : 2'b01);
                if (mq.size() == 15) emit = 1;
            end
            if (trc_on && flush_req && mq.size() > 0) emit = 1;
            if (emit) begin
                if (!m_valid || pkt_ready) begin
                    m_valid = 1;
                    m_pbuf = pack_q(mq);
                    m_pcnt = mq.size();
                end else begin
                    dropped = 1;
                end
                mq.delete();
            end else if (m_valid && pkt_ready) begin
                m_valid = 0;
            end
            if (dropped) begin
                m_ovf = 1;
                m_drop = ovf_clr ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
            end else if (ovf_clr) begin
                m_ovf = 0;
                m_drop = 0;
            end
            m_prev_trc = trc_on;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("dct_count", 32'(dct_count), 32'(mq.size()));
            chk("dct_buffer", 32'(dct_buffer), 32'(pack_q(mq)));
            chk("pkt_valid", 32'(pkt_valid), 32'(m_valid));
            if (m_valid) begin
                chk("pkt_buffer", 32'(pkt_buffer), 32'(m_pbuf));
                chk("pkt_count", 32'(pkt_count), 32'(m_pcnt));
            end
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        end
    end

    task automatic idle();
        dct_valid = 0;
        flush_req = 0;
        ovf_clr = 0;
    endtask

    task automatic acc(input bit tk, input bit fl);
        dct_valid = 1;
        dct_taken = tk;
        flush_req = fl;
        @(negedge clk);
        idle();
    endtask

    initial begin
        reset = 1;
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(dct_count), 0);
        chk("rst_valid", 32'(pkt_valid), 0);
        reset = 0;
        trc_on = 1;

        acc(1, 0);
        acc(0, 0);
        acc(1, 0);
        chk("part_cnt", 32'(dct_count), 3);
        flush_req = 1;
        @(negedge clk);
        idle();
        chk("part_buf", 32'(pkt_buffer), 32'h26);
        chk("part_pcnt", 32'(pkt_count), 3);
        chk("part_valid", 32'(pkt_valid), 1);
        chk("part_live", 32'(dct_count), 0);

        pkt_ready = 1;
        for (int i = 0; i < 15; i++) acc(1, 0);
        chk("full_buf", 32'(pkt_buffer), 32'h2AAA_AAAA);
        chk("full_pcnt", 32'(pkt_count), 15);
        chk("full_live", 32'(dct_count), 0);
        acc(1, 0);
        chk("after_full", 32'(dct_count), 1);

        acc(0, 0);
        acc(1, 1);
        chk("flacc_pcnt", 32'(pkt_count), 3);
        chk("flacc_buf", 32'(pkt_buffer), 32'b10_01_10);

        @(negedge clk);
        pkt_ready = 0;
        acc(1, 1);
        acc(0, 1);
        chk("bp_valid", 32'(pkt_valid), 1);
        chk("bp_buf", 32'(pkt_buffer), 32'h2);
        chk("bp_pcnt", 32'(pkt_count), 1);
        chk("bp_ovf", 32'(overflow), 1);
        chk("bp_drop", 32'(drop_cnt), 1);
        ovf_clr = 1;
        @(negedge clk);
        idle();
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_drop", 32'(drop_cnt), 0);

        pkt_ready = 1;
        for (int i = 0; i < 5; i++) acc(0, 0);
        trc_on = 0;
        @(negedge clk);
        chk("off_pcnt", 32'(pkt_count), 5);
        chk("off_valid", 32'(pkt_valid), 1);
        for (int i = 0; i < 3; i++) acc(1, 1);
        chk("off_live", 32'(dct_count), 0);

        trc_on = 1;
        pkt_ready = 0;
        acc(1, 1);
        for (int i = 0; i < 7; i++) acc(0, 0);
        chk("pre_rst_cnt", 32'(dct_count), 7);
        reset = 1;
        @(negedge clk);
        chk("rst_live", 32'(dct_count), 0);
        chk("rst_buf", 32'(dct_buffer), 0);
        chk("rst_pv", 32'(pkt_valid), 0);
        reset = 0;
        trc_on = 0;
        @(negedge clk);
        chk("rst_noemit", 32'(pkt_valid), 0);

        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 499) == 0);
            trc_on    = ($urandom_range(0, 39) == 0) ? ~trc_on : trc_on;
            dct_valid = ($urandom_range(0, 3) != 0);
            dct_taken = $urandom_range(0, 1);
            flush_req = ($urandom_range(0, 9) == 0);
            ovf_clr   = ($urandom_range(0, 29) == 0);
            pkt_ready = (c % 1000 < 500) ? ($urandom_range(0, 9) == 0)
                                         : ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        reset = 0;
        idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
